// File: rtl/barrel_rot_sched.sv
// Two-client arbiter feeding one shared 8-bit rotate-right unit into a single result register.
// Optional grant counters (grant_cnt0/grant_cnt1) are built when BARREL_ROT_STATS_EN is defined.
module barrel_rot_sched #(
   parameter int FIXED_PRIO = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic [2:0] req0_shamt,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic [2:0] req1_shamt,
   output logic       req1_ready,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_id,
   input  logic       rsp_ready
`ifdef BARREL_ROT_STATS_EN
   ,
   output logic [7:0] grant_cnt0,
   output logic [7:0] grant_cnt1
`endif
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t      state;
   logic        last_grant;
   logic        slot_free;
   logic        gnt0;
   logic        gnt1;
   logic        accept;
   logic [7:0]  sel_data_p0;
   logic [2:0]  sel_shamt_p0;

   function automatic logic [7:0] rotr(input logic [7:0] d, input logic [2:0] s);
      logic [15:0] t;
      t = {d, d} >> s;
      return t[7:0];
   endfunction

   // Stage p0: arbitration and operand select, all combinational.
   always_comb begin
      slot_free    = (state == EMPTY) || rsp_ready;
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      if (rst_n && slot_free) begin
         if (req0_valid && req1_valid) begin
            // last_grant=1 means client 1 went last, so client 0 is due.
            if ((FIXED_PRIO != 0) || last_grant) gnt0 = 1'b1;
            else                                 gnt1 = 1'b1;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
      accept       = gnt0 | gnt1;
      sel_data_p0  = gnt1 ? req1_data  : req0_data;
      sel_shamt_p0 = gnt1 ? req1_shamt : req0_shamt;
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign rsp_valid  = (state == FULL);

   // Stage p1: result register and EMPTY/FULL state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         rsp_data   <= 8'h00;
         rsp_id     <= 1'b0;
         last_grant <= 1'b1;
      end else if (accept) begin
         state      <= FULL;
         rsp_data   <= rotr(sel_data_p0, sel_shamt_p0);
         rsp_id     <= gnt1;
         last_grant <= gnt1;
      end else if (state == FULL && rsp_ready) begin
         state      <= EMPTY;
      end
   end

`ifdef BARREL_ROT_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0 <= 8'h00;
         grant_cnt1 <= 8'h00;
      end else begin
         if (gnt0) grant_cnt0 <= grant_cnt0 + 8'h01;
         if (gnt1) grant_cnt1 <= grant_cnt1 + 8'h01;
      end
   end
`endif

endmodule

// File: tb/tb_barrel_rot_sched.sv
// Bench for barrel_rot_sched: a round-robin and a fixed-priority instance share stimulus,
// each checked against a transaction-level model of the scheduler.
module tb_barrel_rot_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       v0, v1, rr;
   logic [7:0] d0, d1;
   logic [2:0] s0, s1;

   logic       rdy0 [2];
   logic       rdy1 [2];
   logic       ov   [2];
   logic [7:0] od   [2];
   logic       oid  [2];
`ifdef BARREL_ROT_STATS_EN
   logic [7:0] gc0  [2];
   logic [7:0] gc1  [2];
`endif

   int ncmp = 0;
   int nfail = 0;

   // Reference model state, index 0 = round-robin, 1 = fixed priority
   bit         mv    [2];
   logic [7:0] md    [2];
   bit         mid   [2];
   bit         mlast [2];
   int         mcnt0 [2];
   int         mcnt1 [2];
   bit         er0   [2];
   bit         er1   [2];

   always #5 clk = ~clk;

   barrel_rot_sched #(.FIXED_PRIO(0)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_data(d0), .req0_shamt(s0), .req0_ready(rdy0[0]),
      .req1_valid(v1), .req1_data(d1), .req1_shamt(s1), .req1_ready(rdy1[0]),
      .rsp_valid(ov[0]), .rsp_data(od[0]), .rsp_id(oid[0]), .rsp_ready(rr)
`ifdef BARREL_ROT_STATS_EN
      , .grant_cnt0(gc0[0]), .grant_cnt1(gc1[0])
`endif
   );

   barrel_rot_sched #(.FIXED_PRIO(1)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_data(d0), .req0_shamt(s0), .req0_ready(rdy0[1]),
      .req1_valid(v1), .req1_data(d1), .req1_shamt(s1), .req1_ready(rdy1[1]),
      .rsp_valid(ov[1]), .rsp_data(od[1]), .rsp_id(oid[1]), .rsp_ready(rr)
`ifdef BARREL_ROT_STATS_EN
      , .grant_cnt0(gc0[1]), .grant_cnt1(gc1[1])
`endif
   );

   function automatic logic [7:0] ref_rot(input logic [7:0] d, input int s);
      logic [7:0] x;
      x = d;
      for (int i = 0; i < s; i++) x = {x[0], x[7:1]};
      return x;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mv[k] = 0; md[k] = 8'h00; mid[k] = 0; mlast[k] = 1;
         mcnt0[k] = 0; mcnt1[k] = 0;
      end
   endtask

   task automatic predict();
      for (int k = 0; k < 2; k++) begin
         bit free;
         free = !mv[k] || rr;
         er0[k] = 0; er1[k] = 0;
         if (rst_n && free) begin
            if (v0 && v1) begin
               if (k == 1 || mlast[k] == 1) er0[k] = 1;
               else                         er1[k] = 1;
            end else begin
               er0[k] = v0; er1[k] = v1;
            end
         end
      end
   endtask

   task automatic check_out(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s.rsp_valid[%0d]", tag, k), ov[k], mv[k]);
         chk($sformatf("%s.rsp_data[%0d]", tag, k), od[k], md[k]);
         chk($sformatf("%s.rsp_id[%0d]", tag, k), oid[k], mid[k]);
`ifdef BARREL_ROT_STATS_EN
         chk($sformatf("%s.cnt0[%0d]", tag, k), gc0[k], mcnt0[k] % 256);
         chk($sformatf("%s.cnt1[%0d]", tag, k), gc1[k], mcnt1[k] % 256);
`endif
      end
   endtask

   // One clock: check readies against the model, take the edge, then check outputs.
   task automatic cycle(input string tag);
      predict();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s.rdy0[%0d]", tag, k), rdy0[k], er0[k]);
         chk($sformatf("%s.rdy1[%0d]", tag, k), rdy1[k], er1[k]);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (er0[k]) begin
            mv[k] = 1; md[k] = ref_rot(d0, s0); mid[k] = 0; mlast[k] = 0; mcnt0[k]++;
         end else if (er1[k]) begin
            mv[k] = 1; md[k] = ref_rot(d1, s1); mid[k] = 1; mlast[k] = 1; mcnt1[k]++;
         end else if (mv[k] && rr) begin
            mv[k] = 0;
         end
      end
      #1;
      check_out(tag);
   endtask

   task automatic drive(input logic a0, input logic [7:0] a_d0, input logic [2:0] a_s0,
                        input logic a1, input logic [7:0] a_d1, input logic [2:0] a_s1,
                        input logic a_rr);
      v0 = a0; d0 = a_d0; s0 = a_s0;
      v1 = a1; d1 = a_d1; s1 = a_s1;
      rr = a_rr;
      #1;
   endtask

   initial begin
      // Reset with both clients requesting
      rst_n = 1'b0;
      drive(1, 8'hFF, 3'd1, 1, 8'hEE, 3'd2, 1);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("reset.rdy0", rdy0[k], 1'b0);
         chk("reset.rdy1", rdy1[k], 1'b0);
      end
      check_out("reset");
      rst_n = 1'b1;
      drive(0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 1);

      // Directed rotations from client 0
      drive(1, 8'hB1, 3'd3, 0, 8'h00, 3'd0, 1);
      cycle("rot_b1");
      chk("rot_b1.lit", od[0], 8'h36);
      drive(1, 8'h01, 3'd7, 0, 8'h00, 3'd0, 1);
      cycle("rot_01");
      chk("rot_01.lit", od[0], 8'h02);
      drive(1, 8'h5A, 3'd0, 0, 8'h00, 3'd0, 1);
      cycle("rot_5a");
      chk("rot_5a.lit", od[0], 8'h5A);

      // Both clients continuously requesting, consumer always ready
      drive(1, 8'h11, 3'd1, 1, 8'h22, 3'd2, 1);
      for (int i = 0; i < 4; i++) begin
         cycle("alt");
         chk("alt.id_lit", oid[0], (i % 2 == 0) ? 1'b1 : 1'b0);
         chk("fp.id_lit", oid[1], 1'b0);
      end

      // Back-pressure for 3 cycles, then drain and accept client 1 together
      drive(1, 8'h33, 3'd4, 1, 8'h44, 3'd5, 0);
      for (int i = 0; i < 3; i++) cycle("hold");
      drive(0, 8'h00, 3'd0, 1, 8'hC3, 3'd2, 1);
      cycle("drain_acc");
      chk("drain_acc.id_lit", oid[0], 1'b1);
      chk("drain_acc.data_lit", od[0], 8'hF0);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 1), 8'($urandom), 3'($urandom),
               $urandom_range(0, 1), 8'($urandom), 3'($urandom),
               $urandom_range(0, 3) != 0);
         cycle("rand");
      end

      // Reset asserted while a result is held
      drive(1, 8'h81, 3'd1, 0, 8'h00, 3'd0, 0);
      cycle("pre_rst");
      rst_n = 1'b0;
      model_reset();
      #1;
      check_out("mid_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1, 8'h0F, 3'd4, 1, 8'hF0, 3'd4, 1);
      cycle("post_rst");
      chk("post_rst.id_lit", oid[0], 1'b0);

      // Client 0 only, 256 accepts from a clean reset
      rst_n = 1'b0;
      model_reset();
      #1;
      rst_n = 1'b1;
      drive(1, 8'h00, 3'd0, 0, 8'h00, 3'd0, 1);
      for (int i = 0; i < 256; i++) begin
         d0 = 8'($urandom); s0 = 3'($urandom); #1;
         cycle("cnt");
      end
`ifdef BARREL_ROT_STATS_EN
      chk("cnt.wrap0", gc0[0], 8'h00);
      chk("cnt.wrap1", gc1[0], 8'h00);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
